input_slice_sequencer: RTL and testbench

Upstream feeder for the input-side bit-slice MUX register. Reads 32-bit words from the input buffer SRAM, holds each word stable, and steps the 2-bit slice index (`state`) through every slice the current weight bitwidth requires, handing each (word, slice) pair downstream with a valid/ready handshake. Its outputs `buffer` and `state` drive the MUX register's `buffer` and `state` inputs directly. Also reports run completion to the layer controller.

---
 rtl/input_slice_sequencer_if.sv | 30 +++
 rtl/input_slice_sequencer.sv | 110 +++++++++++
 tb/tb_input_slice_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_slice_sequencer_if.sv
// Bundle of the command, SRAM-read and slice-output signals of the input slice sequencer.
// The slave modport is the sequencer; the master modport is the controller/SRAM/consumer side.
interface input_slice_sequencer_if #(
  parameter int ADDR_W = 10
) ();
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_words;
  logic [1:0]        weight_bitwidth;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [31:0]       buf_rd_data;
  logic [31:0]       buffer;
  logic [1:0]        state;
  logic [1:0]        weight_bitwidth_q;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, num_words, weight_bitwidth, buf_rd_data, out_ready,
    input  buf_rd_en, buf_rd_addr, buffer, state, weight_bitwidth_q, out_valid, busy, done
  );

  modport slave (
    input  start, base_addr, num_words, weight_bitwidth, buf_rd_data, out_ready,
    output buf_rd_en, buf_rd_addr, buffer, state, weight_bitwidth_q, out_valid, busy, done
  );
endinterface

// File: rtl/input_slice_sequencer.sv
// Fetches words from the input buffer SRAM and presents every bit-slice of each word,
// one (word, slice) pair per valid/ready handshake, to the bit-slice MUX register.
module input_slice_sequencer #(
  parameter int ADDR_W = 10
) (
  input logic                    clk,
  input logic                    reset,
  input_slice_sequencer_if.slave sif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_DONE
  } fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [31:0]       buffer_q, buffer_d;
  logic [1:0]        slice_q, slice_d;
  logic [1:0]        wbw_q, wbw_d;
  logic              last_slice;

  // 8-bit weights use one slice per word, 4-bit two, 2-bit (10 or 11) four.
  always_comb begin
    unique case (wbw_q)
      2'b00:   last_slice = (slice_q == 2'd0);
      2'b01:   last_slice = (slice_q == 2'd1);
      default: last_slice = (slice_q == 2'd3);
    endcase
  end

  // NOTE: every next-state signal takes its held value first, so no path through
  // the case below can leave one unassigned and infer a latch.
  always_comb begin
    fsm_d       = fsm_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    buffer_d    = buffer_q;
    slice_d     = slice_q;
    wbw_d       = wbw_q;

    unique case (fsm_q)
      S_IDLE: begin
        if (sif.start) begin
          addr_d      = sif.base_addr;
          remaining_d = sif.num_words;
          wbw_d       = sif.weight_bitwidth;
          fsm_d       = (sif.num_words == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: fsm_d = S_WAIT;
      S_WAIT: begin
        buffer_d = sif.buf_rd_data;
        slice_d  = 2'd0;
        fsm_d    = S_EMIT;
      end
      S_EMIT: begin
        if (sif.out_ready) begin
          if (!last_slice) begin
            slice_d = slice_q + 2'd1;
          end else if (remaining_q > ADDR_W'(1)) begin
            remaining_d = remaining_q - ADDR_W'(1);
            addr_d      = addr_q + ADDR_W'(1);
            fsm_d       = S_FETCH;
          end else begin
            fsm_d = S_DONE;
          end
        end
      end
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      buffer_q    <= '0;
      slice_q     <= '0;
      wbw_q       <= '0;
    end else begin
      fsm_q       <= fsm_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      buffer_q    <= buffer_d;
      slice_q     <= slice_d;
      wbw_q       <= wbw_d;
    end
  end

  // Outputs come straight from registers or the state decode; out_ready and start
  // never reach an output combinationally.
  assign sif.buf_rd_en         = (fsm_q == S_FETCH);
  assign sif.buf_rd_addr       = addr_q;
  assign sif.buffer            = buffer_q;
  assign sif.state             = slice_q;
  assign sif.weight_bitwidth_q = wbw_q;
  assign sif.out_valid         = (fsm_q == S_EMIT);
  assign sif.busy              = (fsm_q != S_IDLE);
  assign sif.done              = (fsm_q == S_DONE);

endmodule

// File: tb/tb_input_slice_sequencer.sv
// Scoreboard bench for input_slice_sequencer: a run-level model pushes expected reads,
// beats and done pulses; a negedge monitor pops and compares them as the DUT presents them.
module tb_input_slice_sequencer;
  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [31:0] word;
    logic [1:0]  slice;
    logic [1:0]  wbw;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic ready_manual_en, ready_manual, ready_rand;
  logic [31:0] mem [0:(1<<ADDR_W)-1];

  beat_t             exp_beats[$];
  logic [ADDR_W-1:0] exp_addrs[$];
  int                done_pending;
  int                tests_run;
  int                tests_failed;

  input_slice_sequencer_if #(.ADDR_W(ADDR_W)) sif ();

  input_slice_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  always #5 clk = ~clk;

  assign sif.out_ready = ready_manual_en ? ready_manual : ready_rand;

  // SRAM model: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (sif.buf_rd_en) sif.buf_rd_data <= mem[sif.buf_rd_addr];
  end

  initial begin
    ready_rand = 1'b1;
    forever begin
      @(posedge clk);
      #1 ready_rand = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got %h where nothing was expected at %0t", name, act, $time);
  endtask

  // Expected behaviour of one run, straight from the rules: each word read once at
  // consecutive (wrapping) addresses, then 1/2/4 beats of that word, then one done.
  task automatic push_run(input logic [ADDR_W-1:0] base, input int n, input logic [1:0] wbw);
    int slices;
    slices = (wbw == 2'b00) ? 1 : (wbw == 2'b01) ? 2 : 4;
    for (int w = 0; w < n; w++) begin
      logic [ADDR_W-1:0] a;
      a = base + ADDR_W'(w);
      exp_addrs.push_back(a);
      for (int s = 0; s < slices; s++) exp_beats.push_back('{mem[a], 2'(s), wbw});
    end
    done_pending++;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (sif.buf_rd_en) begin
        if (exp_addrs.size() == 0) flag("read_addr", 32'(sif.buf_rd_addr));
        else check("read_addr", 32'(sif.buf_rd_addr), 32'(exp_addrs.pop_front()));
      end
      if (sif.out_valid && sif.out_ready) begin
        if (exp_beats.size() == 0) flag("beat", {sif.buffer});
        else begin
          beat_t b;
          b = exp_beats.pop_front();
          check("beat_buffer", sif.buffer, b.word);
          check("beat_state", 32'(sif.state), 32'(b.slice));
          check("beat_wbw_q", 32'(sif.weight_bitwidth_q), 32'(b.wbw));
        end
      end
      if (sif.done) begin
        if (done_pending == 0) flag("done_pulse", 32'(sif.done));
        else done_pending--;
        check("beats_left_at_done", 32'(exp_beats.size()), 32'd0);
        check("reads_left_at_done", 32'(exp_addrs.size()), 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},  32'(sif.buf_rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(sif.buf_rd_addr), 32'd0);
    check({tag, "_buffer"}, sif.buffer, 32'd0);
    check({tag, "_state"},  32'(sif.state), 32'd0);
    check({tag, "_wbw_q"},  32'(sif.weight_bitwidth_q), 32'd0);
    check({tag, "_valid"},  32'(sif.out_valid), 32'd0);
    check({tag, "_busy"},   32'(sif.busy), 32'd0);
    check({tag, "_done"},   32'(sif.done), 32'd0);
  endtask

  // Issues start for one edge and returns #1 after the accepting edge.
  task automatic start_run(input logic [ADDR_W-1:0] base, input int n, input logic [1:0] wbw);
    @(posedge clk);
    #1;
    sif.base_addr       = base;
    sif.num_words       = ADDR_W'(n);
    sif.weight_bitwidth = wbw;
    sif.start           = 1'b1;
    push_run(base, n, wbw);
    @(posedge clk);
    #1;
    sif.start           = 1'b0;
    sif.base_addr       = ADDR_W'($urandom);
    sif.num_words       = ADDR_W'($urandom);
    sif.weight_bitwidth = 2'($urandom);
  endtask

  // Returns at the negedge where done is seen, then checks the pulse width and busy.
  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sif.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) flag("done_timeout", 32'(budget));
    @(negedge clk);
    check("done_one_cycle", 32'(sif.done), 32'd0);
    check("busy_after_done", 32'(sif.busy), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sif.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) flag("valid_timeout", 32'(budget));
  endtask

  initial begin
    tests_run           = 0;
    tests_failed        = 0;
    done_pending        = 0;
    reset               = 1'b1;
    sif.start           = 1'b0;
    sif.base_addr       = '0;
    sif.num_words       = '0;
    sif.weight_bitwidth = '0;
    ready_manual_en     = 1'b1;
    ready_manual        = 1'b1;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1 reset = 1'b0;

    // 8-bit, three words, with first-read and first-beat latency checks.
    mem[10'h010] = 32'h11111111;
    mem[10'h011] = 32'h22222222;
    mem[10'h012] = 32'h33333333;
    start_run(10'h010, 3, 2'b00);
    @(negedge clk);
    check("lat_rd_en_t1", 32'(sif.buf_rd_en), 32'd1);
    check("lat_busy_t1", 32'(sif.busy), 32'd1);
    @(negedge clk);
    check("lat_valid_t2", 32'(sif.out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_t3", 32'(sif.out_valid), 32'd1);
    wait_done(100);

    // 4-bit, one word.
    mem[10'h100] = 32'hA5A53C3C;
    start_run(10'h100, 1, 2'b01);
    wait_done(100);

    // 2-bit, one word, downstream stalls five cycles on slice 2.
    mem[10'h200] = 32'hDEADBEEF;
    ready_manual = 1'b0;
    start_run(10'h200, 1, 2'b10);
    wait_valid(20);
    @(posedge clk);
    #1 ready_manual = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 ready_manual = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_state", 32'(sif.state), 32'd2);
      check("stall_buffer", sif.buffer, 32'hDEADBEEF);
      check("stall_valid", 32'(sif.out_valid), 32'd1);
    end
    @(posedge clk);
    #1 ready_manual = 1'b1;
    wait_done(50);

    // Empty run: done the cycle after start, no read.
    start_run(10'h055, 0, 2'b11);
    @(negedge clk);
    check("empty_done", 32'(sif.done), 32'd1);
    check("empty_no_read", 32'(sif.buf_rd_en), 32'd0);
    @(negedge clk);
    check("empty_busy_after", 32'(sif.busy), 32'd0);

    // Second start while busy is dropped: exactly two reads, no second run.
    start_run(10'h300, 2, 2'b01);
    @(posedge clk);
    #1;
    sif.start     = 1'b1;
    sif.base_addr = 10'h000;
    sif.num_words = 10'd5;
    @(posedge clk);
    #1 sif.start = 1'b0;
    wait_done(100);
    repeat (3) @(negedge clk);
    check("dropped_start_idle", 32'(sif.busy), 32'd0);

    // Address wrap from the top of the buffer.
    start_run(10'h3FF, 2, 2'b00);
    wait_done(100);

    // Reset while the second word is being emitted.
    start_run(10'h020, 3, 2'b01);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (sif.out_valid && sif.buf_rd_addr == 10'h021) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) flag("word2_timeout", 32'(sif.buf_rd_addr));
    end
    #1;
    reset        = 1'b1;
    ready_manual = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrun");
    exp_beats.delete();
    exp_addrs.delete();
    done_pending = 0;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    ready_manual = 1'b1;
    start_run(10'h040, 2, 2'b10);
    wait_done(100);

    // Randomised runs with random downstream back-pressure.
    ready_manual_en = 1'b0;
    for (int r = 0; r < 25; r++) begin
      start_run(ADDR_W'($urandom), $urandom_range(0, 5), 2'($urandom));
      wait_done(400);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
